// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding, transmitter bit-counter codes and the round-robin pick helper.
package uart_tx_arbiter_pkg;

    localparam int unsigned N_REQ      = 4;
    localparam logic [3:0]  BCNT_IDLE  = 4'hf;
    localparam logic [3:0]  BCNT_START = 4'h0;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StLoad      = 3'd1,
        StWaitStart = 3'd2,
        StSending   = 3'd3,
        StDone      = 3'd4
    } arb_state_e;

    // First set request at or after ptr, wrapping; descending scan so the nearest wins.
    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_baud_gen.sv
// Free-running baud clock: txck low for the first half of each DIV-cycle period.
// txck_rise marks the first cycle in which txck is high.
module uart_baud_gen #(
    parameter int unsigned DIV = 434
) (
    input  logic clk,
    input  logic rst,
    output logic txck,
    output logic txck_rise
);

    localparam int unsigned CntW = $clog2(DIV);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic            r_txck;
    logic            r_rise;

    assign w_cnt_next = (r_cnt == CntW'(DIV - 1)) ? '0 : r_cnt + CntW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_txck <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_txck <= (w_cnt_next >= CntW'(DIV / 2));
            r_rise <= (w_cnt_next == CntW'(DIV / 2));
        end
    end

    assign txck      = r_txck;
    assign txck_rise = r_rise;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four requesters.
// Grants a requester, hands its byte to the transmitter and reports ack or timeout err.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned START_TMO = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   err,
    output logic               busy,
    output logic [1:0]         grant_id,
    output logic               txck,
    output logic [7:0]         txpd,
    output logic               tstart,
    input  logic [3:0]         bcnt
);

    localparam int unsigned TmoW = $clog2(START_TMO + 2);

    logic            w_txck_rise;
    logic [1:0]      w_pick;
    logic [TmoW-1:0] w_tmo_next;

    arb_state_e      r_state;
    logic [1:0]      r_rr_ptr;
    logic [1:0]      r_grant;
    logic [7:0]      r_txpd;
    logic            r_tstart;
    logic            r_busy;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_err;
    logic [TmoW-1:0] r_tmo;

    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .txck      (txck),
        .txck_rise (w_txck_rise)
    );

    assign w_pick     = rr_pick(req, r_rr_ptr);
    assign w_tmo_next = r_tmo + TmoW'(w_txck_rise);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_rr_ptr <= 2'd0;
            r_grant  <= 2'd0;
            r_txpd   <= 8'd0;
            r_tstart <= 1'b0;
            r_busy   <= 1'b0;
            r_ack    <= '0;
            r_err    <= '0;
            r_tmo    <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            unique case (r_state)
                StIdle: begin
                    if (|req) begin
                        r_grant  <= w_pick;
                        r_txpd   <= req_data[{w_pick, 3'b000} +: 8];
                        r_tstart <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= StLoad;
                    end
                end
                StLoad: begin
                    // A txck edge landing in this cycle already counts toward the timeout.
                    r_tmo   <= TmoW'(w_txck_rise);
                    r_state <= StWaitStart;
                end
                StWaitStart: begin
                    if (bcnt == BCNT_START) begin
                        r_tstart <= 1'b0;
                        r_state  <= StSending;
                    end else if (w_tmo_next >= TmoW'(START_TMO)) begin
                        r_err[r_grant] <= 1'b1;
                        r_rr_ptr       <= r_grant + 2'd1;
                        r_tstart       <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= StIdle;
                    end else begin
                        r_tmo <= w_tmo_next;
                    end
                end
                StSending: begin
                    if (bcnt == BCNT_IDLE) begin
                        r_ack[r_grant] <= 1'b1;
                        r_rr_ptr       <= r_grant + 2'd1;
                        r_state        <= StDone;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_tstart <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign busy     = r_busy;
    assign grant_id = r_grant;
    assign txpd     = r_txpd;
    assign tstart   = r_tstart;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART transmitter
// and a round-robin reference model built from queues.
module tb_uart_tx_arbiter;

    localparam int unsigned BAUD_DIV  = 8;
    localparam int unsigned START_TMO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        busy;
    logic [1:0]  grant_id;
    logic        txck;
    logic [7:0]  txpd;
    logic        tstart;
    logic [3:0]  bcnt;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .BAUD_DIV  (BAUD_DIV),
        .START_TMO (START_TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .txck     (txck),
        .txpd     (txpd),
        .tstart   (tstart),
        .bcnt     (bcnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural transmitter: acts on each txck rise, start bit, 8 data bits LSB first, stop.
    logic       tx_en = 1'b1;
    logic [3:0] m_bcnt;
    logic [7:0] m_shift;
    logic       m_txck_d;
    int unsigned sent_q[$];
    bit          line_q[$];
    int          stamp_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_bcnt   <= 4'hf;
            m_txck_d <= 1'b0;
        end else begin
            m_txck_d <= txck;
            if (txck && !m_txck_d) begin
                if (m_bcnt == 4'hf) begin
                    if (tx_en && tstart) begin
                        m_bcnt  <= 4'd0;
                        m_shift <= txpd;
                        line_q.push_back(1'b0);
                        stamp_q.push_back(cyc);
                    end
                end else if (m_bcnt == 4'd9) begin
                    m_bcnt <= 4'hf;
                    sent_q.push_back(int'(m_shift));
                end else if (m_bcnt == 4'd8) begin
                    m_bcnt <= 4'd9;
                    line_q.push_back(1'b1);
                    stamp_q.push_back(cyc);
                end else begin
                    m_bcnt <= m_bcnt + 4'd1;
                    line_q.push_back(m_shift[m_bcnt[2:0]]);
                    stamp_q.push_back(cyc);
                end
            end
        end
    end

    assign bcnt = tx_en ? m_bcnt : 4'hf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: requests presented together are served in rotation from the pointer.
    int exp_q[$];
    int model_ptr = 0;

    function automatic void model_serve(input logic [3:0] mask);
        logic [3:0] pend;
        int idx;
        pend = mask;
        while (pend != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                idx = (model_ptr + k) % 4;
                if (pend[idx]) begin
                    exp_q.push_back(idx);
                    pend[idx] = 1'b0;
                    model_ptr = (idx + 1) % 4;
                    break;
                end
            end
        end
    endfunction

    // Raise mask, drop each bit on its ack, then compare the ack order and bytes with exp_q.
    task automatic run_frames(input logic [3:0] mask, input logic [31:0] data, input string tag);
        int got_q[$];
        int budget;
        bit gap_chk;
        sent_q.delete();
        req_data = data;
        req      = mask;
        budget   = 2000;
        gap_chk  = 1'b0;
        while ((req != 4'd0 || gap_chk) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (gap_chk) begin
                check({tag, " idle gap busy"}, 32'(busy), 32'd0);
                gap_chk = 1'b0;
            end
            if (err != 4'd0) check({tag, " unexpected err"}, 32'(err), 32'd0);
            if (ack != 4'd0) begin
                check({tag, " ack onehot"}, 32'($onehot(ack)), 32'd1);
                check({tag, " busy at ack"}, 32'(busy), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) begin
                        got_q.push_back(i);
                        check({tag, " grant_id"}, 32'(grant_id), 32'(i));
                        check({tag, " txpd held"}, 32'(txpd), 32'(data[8*i +: 8]));
                        req[i] = 1'b0;
                    end
                end
                gap_chk = 1'b1;
            end
        end
        if (budget == 0) check({tag, " frames pending at bound"}, 32'(req), 32'd0);
        check({tag, " frame count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check({tag, " order"}, 32'(got_q[k]), 32'(exp_q[k]));
        for (int k = 0; k < exp_q.size() && k < sent_q.size(); k++)
            check({tag, " line byte"}, 32'(sent_q[k]), 32'(data[8*exp_q[k] +: 8]));
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          n;
        int          ord[4];
    } vec_t;

    vec_t tbl[5];

    function automatic vec_t mk(input logic [3:0] m, input logic [31:0] d, input int n,
                                input int o0, input int o1, input int o2, input int o3);
        vec_t v;
        v.mask = m;
        v.data = d;
        v.n    = n;
        v.ord[0] = o0;
        v.ord[1] = o1;
        v.ord[2] = o2;
        v.ord[3] = o3;
        return v;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time bound reached");
        $fatal(1);
    end

    initial begin
        int got_f[$];
        int exp_f[3];
        bit exp_bits[10];
        int budget;
        int rises;
        int bad;
        bit prev;
        bit seen;
        logic [3:0] rmask;
        logic [31:0] rdata;

        // Pointer runs 0 -> 0 -> 3 -> 2 -> 2 -> 0 through these vectors.
        tbl[0] = mk(4'b1111, 32'h44332211, 4, 0, 1, 2, 3);
        tbl[1] = mk(4'b0101, 32'h9C5A3E17, 2, 0, 2, 0, 0);
        tbl[2] = mk(4'b1010, 32'hD4C3B2A1, 2, 3, 1, 0, 0);
        tbl[3] = mk(4'b0011, 32'h0F1E2D3C, 2, 0, 1, 0, 0);
        tbl[4] = mk(4'b1000, 32'h81000000, 1, 3, 0, 0, 0);
        exp_f = '{0, 2, 0};
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset grant_id", 32'(grant_id), 32'd0);
        check("reset txpd", 32'(txpd), 32'd0);
        check("reset tstart", 32'(tstart), 32'd0);
        check("reset txck", 32'(txck), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            for (int k = 0; k < tbl[v].n; k++) exp_q.push_back(tbl[v].ord[k]);
            run_frames(tbl[v].mask, tbl[v].data, $sformatf("vec%0d", v));
            model_ptr = (tbl[v].ord[tbl[v].n - 1] + 1) % 4;
        end

        // Single frame: line pattern and bit period.
        line_q.delete();
        stamp_q.delete();
        exp_q.delete();
        model_serve(4'b0001);
        run_frames(4'b0001, 32'h000000A5, "single");
        check("single bit count", 32'(line_q.size()), 32'd10);
        for (int k = 0; k < 10 && k < line_q.size(); k++)
            check($sformatf("single line bit%0d", k), 32'(line_q[k]), 32'(exp_bits[k]));
        bad = 0;
        for (int k = 1; k < stamp_q.size(); k++)
            if (stamp_q[k] - stamp_q[k-1] != int'(BAUD_DIV)) bad++;
        check("single bit period", 32'(bad), 32'd0);

        // Fairness: req0 held throughout, req2 raised once while req0 is being served.
        req_data = 32'h00AB00CD;
        req = 4'b0001;
        budget = 200;
        while (!busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("fair first grant busy", 32'(busy), 32'd1);
        req[2] = 1'b1;
        budget = 2000;
        while (got_f.size() < 3 && budget > 0) begin
            @(negedge clk);
            budget--;
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    got_f.push_back(i);
                    if (i == 2) req[2] = 1'b0;
                    if (got_f.size() == 3) req[0] = 1'b0;
                end
            end
        end
        req = 4'd0;
        check("fair frame count", 32'(got_f.size()), 32'd3);
        for (int k = 0; k < 3 && k < got_f.size(); k++)
            check($sformatf("fair order%0d", k), 32'(got_f[k]), 32'(exp_f[k]));
        repeat (2) @(negedge clk);
        model_ptr = 1;

        // Timeout: transmitter never accepts.
        tx_en = 1'b0;
        req_data = 32'h00770000;
        req = 4'b0100;
        rises = 0;
        prev = txck;
        seen = 1'b0;
        budget = 400;
        while (!seen && budget > 0) begin
            @(negedge clk);
            budget--;
            if (tstart && txck && !prev) rises++;
            prev = txck;
            if (ack != 4'd0) check("timeout unexpected ack", 32'(ack), 32'd0);
            if (err != 4'd0) begin
                check("timeout err", 32'(err), 32'b0100);
                check("timeout txck rises", 32'(rises), 32'(START_TMO));
                req = 4'd0;
                seen = 1'b1;
            end
        end
        check("timeout err seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        check("timeout busy after", 32'(busy), 32'd0);
        check("timeout ack after", 32'(ack), 32'd0);
        tx_en = 1'b1;
        model_ptr = 3;

        // Randomized traffic against the model.
        for (int r = 0; r < 20; r++) begin
            rmask = 4'($urandom_range(1, 15));
            rdata = $urandom;
            exp_q.delete();
            model_serve(rmask);
            run_frames(rmask, rdata, $sformatf("rand%0d", r));
        end

        // Reset in the middle of a frame.
        req_data = 32'h0000003C;
        req = 4'b0001;
        budget = 500;
        while (bcnt != 4'd4 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("midreset reached bcnt4", 32'(bcnt), 32'd4);
        rst = 1'b0;
        req = 4'd0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset tstart", 32'(tstart), 32'd0);
        check("midreset txpd", 32'(txpd), 32'd0);
        check("midreset grant_id", 32'(grant_id), 32'd0);
        check("midreset txck", 32'(txck), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midreset ack/err quiet", 32'({ack, err}), 32'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("postreset ack/err quiet", 32'({ack, err}), 32'd0);
        end
        model_ptr = 0;
        exp_q.delete();
        model_serve(4'b0010);
        run_frames(4'b0010, 32'h00006900, "postreset single");
        exp_q.delete();
        model_serve(4'b1111);
        run_frames(4'b1111, 32'hE4D3C2B1, "postreset all");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BAUD_DIV, default 434, means clk cycles per txck period; it SHALL be even and at least 4.
REQ-002 Parameter START_TMO, default 3, means the number of txck periods allowed for the transmitter to accept a frame.
REQ-003 Port clk, input, 1 bit: system clock; all logic SHALL be on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port req, input, 4 bits: per-requester transmit request, level, held until ack.
REQ-006 Port req_data, input, 32 bits: byte for requester i on bits [8i+7:8i], stable while req[i] is high.
REQ-007 Port ack, output, 4 bits: one-cycle pulse; the frame for requester i has completed.
REQ-008 Port err, output, 4 bits: one-cycle pulse; the frame for requester i was not accepted before timeout.
REQ-009 Port busy, output, 1 bit: high in every state except IDLE.
REQ-010 Port grant_id, output, 2 bits: index of the current grantee, valid while busy is high.
REQ-011 Port txck, output, 1 bit: baud clock to the transmitter.
REQ-012 Port txpd, output, 8 bits: byte to the transmitter.
REQ-013 Port tstart, output, 1 bit: start level to the transmitter.
REQ-014 Port bcnt, input, 4 bits: transmitter bit counter; 4'hf means idle, 0 means start bit, 9 means stop bit.

Function
REQ-015 Baud generator: a free-running counter 0..BAUD_DIV-1 SHALL drive txck low for counts 0..BAUD_DIV/2-1 and high otherwise; it is not gated by the FSM.
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT_START, SENDING and DONE.
REQ-017 IDLE: when any req bit is high, the block SHALL select the first set bit at or after rr_ptr, wrapping 3->0. It SHALL latch the index into grant_id and the byte into txpd, then go to LOAD.
REQ-018 LOAD: tstart SHALL be 1 and the block SHALL go to WAIT_START next cycle.
REQ-019 WAIT_START: tstart SHALL stay 1.
REQ-020 WAIT_START, exit on acceptance: on bcnt==0 the block SHALL go to SENDING.
REQ-021 WAIT_START, exit on timeout: if START_TMO rising txck edges pass without bcnt==0, err[grant_id] SHALL pulse and the block SHALL go to IDLE; rr_ptr still advances.
REQ-022 SENDING: tstart SHALL be 0 and the block SHALL wait for bcnt==4'hf, then go to DONE.
REQ-023 DONE: ack[grant_id] SHALL pulse for one cycle and rr_ptr SHALL become grant_id+1 mod 4; the next state is IDLE.
REQ-024 txpd SHALL be held constant from the IDLE grant until the block leaves SENDING or times out.
REQ-025 The minimum gap SHALL be one cycle in IDLE between frames; back-to-back requests SHALL be served in strict rotation.
REQ-026 Deassertion of req[i] after grant SHALL NOT abort the frame; ack is still issued.
REQ-027 ack and err SHALL never pulse in the same cycle, and at most one bit of each SHALL be set.

Reset
REQ-028 While rst is low: state=IDLE, rr_ptr=0, grant_id=0, txpd=0, tstart=0, ack=0, err=0, busy=0, txck=0, baud counter=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no ack or err; after release, arbitration restarts from requester 0.

Structure
REQ-030 A shared package SHALL hold the state encoding (3-bit) and the constants BCNT_IDLE=4'hf, BCNT_START=0 and N_REQ=4.
REQ-031 The baud generator SHALL be a sub-module uart_baud_gen with parameter DIV and output txck.

Verification
REQ-032 The bench SHALL use BAUD_DIV=8 and connect the existing UART transmitter unless noted.
REQ-033 Single request: req=4'b0001, byte 8'hA5 -> line carries 0,1,0,1,0,0,1,0,1,1 at bit rate; ack=4'b0001 once; busy falls after ack.
REQ-034 Simultaneous requests: req=4'b1111, bytes 11/22/33/44 -> frames in order 11,22,33,44; acks 0001,0010,0100,1000.
REQ-035 Fairness: req0 held continuously and req2 raised once -> order req0, req2, req0, never two req0 frames while req2 waits.
REQ-036 Timeout: bcnt tied to 4'hf, req=4'b0100 -> err=4'b0100 after 3 txck periods; no ack; busy low afterwards.
REQ-037 Reset mid-frame: rst low at bcnt==4 -> all outputs at reset values; no ack or err; the next req=4'b0010 is served normally.
